// File: rtl/pairhmm_job_scheduler_pkg.sv
// Shared definitions for the Pair-HMM job scheduler slice.
// Contents: base encoding (STRING and the STRING_* constants), the read
// bundles handed to the systolic array (READS, PRIORS), the transition
// probability record, sizing constants, the scheduler state enum and a
// watchdog helper.
package pairhmm_job_scheduler_pkg;

  localparam int MAX_STRING_LENGTH = 16;
  localparam int NUM_PROCS         = 4;
  localparam int ADDR_W            = $clog2(MAX_STRING_LENGTH);

  // Four bases plus a dash, which pads any read past the end of the buffer.
  typedef logic [2:0] STRING;
  localparam STRING STRING_A    = 3'd0;
  localparam STRING STRING_C    = 3'd1;
  localparam STRING STRING_G    = 3'd2;
  localparam STRING STRING_T    = 3'd3;
  localparam STRING STRING_DASH = 3'd4;

  typedef struct packed {
    logic                  valid;
    STRING                 reference;
    STRING [NUM_PROCS-1:0] exp;
  } READS;

  typedef struct packed {
    logic                        valid;
    logic [NUM_PROCS-1:0][63:0]  match;
    logic [NUM_PROCS-1:0][63:0]  neq;
  } PRIORS;

  typedef struct packed {
    logic [63:0] match_to_match;
    logic [63:0] match_to_gap;
    logic [63:0] gap_to_match;
    logic [63:0] gap_to_gap;
  } transition_probs;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} sched_state_t;

  // The count is sampled before it increments, so the limit is reached
  // when it shows limit-1. A limit of 0 switches the watchdog off.
  function automatic logic watchdog_expired(input logic [31:0] count,
                                            input int unsigned limit);
    return (limit != 0) && (count == limit - 1);
  endfunction

endpackage

// File: rtl/pairhmm_job_scheduler_if.sv
// Bundle of every non-clock signal of the scheduler.
// slave  : the scheduler side (takes loads, start, array requests, res_ready)
// master : the host plus systolic array side driving/observing it
interface pairhmm_job_scheduler_if;
  import pairhmm_job_scheduler_pkg::*;

  // host load port
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  STRING             ld_ref;
  STRING             ld_exp;
  logic [63:0]       ld_match;
  logic [63:0]       ld_neq;
  // job launch
  logic              start;
  logic [ADDR_W-1:0] start_len;
  transition_probs   start_tp;
  logic              busy;
  // systolic array side
  logic              sa_reset;
  logic [ADDR_W-1:0] sa_len;
  transition_probs   sa_tp;
  READS              sa_base_reads;
  PRIORS             sa_prior_reads;
  logic              sa_rdx_valid;
  logic [ADDR_W-1:0] sa_rdx_index;
  logic              sa_rdy_valid;
  logic [ADDR_W-1:0] sa_rdy_index;
  logic              sa_complete;
  logic [63:0]       sa_final_val;
  // result handshake
  logic              res_valid;
  logic              res_ready;
  logic [63:0]       res_val;
  logic [31:0]       res_cycles;
  logic              res_timeout;

  modport slave (
    input  ld_valid, ld_addr, ld_ref, ld_exp, ld_match, ld_neq,
    input  start, start_len, start_tp,
    input  sa_rdx_valid, sa_rdx_index, sa_rdy_valid, sa_rdy_index,
    input  sa_complete, sa_final_val, res_ready,
    output ld_ready, busy, sa_reset, sa_len, sa_tp,
    output sa_base_reads, sa_prior_reads,
    output res_valid, res_val, res_cycles, res_timeout
  );

  modport master (
    output ld_valid, ld_addr, ld_ref, ld_exp, ld_match, ld_neq,
    output start, start_len, start_tp,
    output sa_rdx_valid, sa_rdx_index, sa_rdy_valid, sa_rdy_index,
    output sa_complete, sa_final_val, res_ready,
    input  ld_ready, busy, sa_reset, sa_len, sa_tp,
    input  sa_base_reads, sa_prior_reads,
    input  res_valid, res_val, res_cycles, res_timeout
  );

endinterface

// File: rtl/pairhmm_read_buffer.sv
// Per-position storage of reference/experimental bases and priors, plus the
// registered read ports that feed the systolic array.
// Ports: clock, reset; wr_* single write port; clear empties the read
// registers for a new job; x_en/x_index single-base reference read;
// y_en/y_index NP-wide window of experimental bases and priors;
// base_reads/prior_reads registered results with sticky valid bits.
// The storage itself is never reset so loaded data survives a reset.
module pairhmm_read_buffer
  import pairhmm_job_scheduler_pkg::*;
#(
  parameter int MAX_LEN = MAX_STRING_LENGTH,
  parameter int NP      = NUM_PROCS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  STRING                      wr_ref,
  input  STRING                      wr_exp,
  input  logic [63:0]                wr_match,
  input  logic [63:0]                wr_neq,
  input  logic                       clear,
  input  logic                       x_en,
  input  logic [$clog2(MAX_LEN)-1:0] x_index,
  input  logic                       y_en,
  input  logic [$clog2(MAX_LEN)-1:0] y_index,
  output READS                       base_reads,
  output PRIORS                      prior_reads
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [AW:0] LEN_W = (AW+1)'(MAX_LEN);

  STRING       ref_mem   [MAX_LEN];
  STRING       exp_mem   [MAX_LEN];
  logic [63:0] match_mem [MAX_LEN];
  logic [63:0] neq_mem   [MAX_LEN];

  READS  reads_next;
  PRIORS priors_next;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      ref_mem[wr_addr]   <= wr_ref;
      exp_mem[wr_addr]   <= wr_exp;
      match_mem[wr_addr] <= wr_match;
      neq_mem[wr_addr]   <= wr_neq;
    end
  end

  // Fields not requested this cycle keep their previous contents. The y
  // window is computed one bit wider so positions past the end are padded
  // instead of wrapping back to the start of the buffer.
  always_comb begin
    logic [AW:0] widx;
    widx        = '0;
    reads_next  = base_reads;
    priors_next = prior_reads;
    if (x_en) begin
      reads_next.valid     = 1'b1;
      reads_next.reference = ref_mem[x_index];
    end
    if (y_en) begin
      priors_next.valid = 1'b1;
      for (int i = 0; i < NP; i++) begin
        widx = {1'b0, y_index} + (AW+1)'(i);
        if (widx < LEN_W) begin
          reads_next.exp[i]    = exp_mem[widx[AW-1:0]];
          priors_next.match[i] = match_mem[widx[AW-1:0]];
          priors_next.neq[i]   = neq_mem[widx[AW-1:0]];
        end else begin
          reads_next.exp[i]    = STRING_DASH;
          priors_next.match[i] = '0;
          priors_next.neq[i]   = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      base_reads  <= '0;
      prior_reads <= '0;
    end else begin
      base_reads  <= reads_next;
      prior_reads <= priors_next;
    end
  end

endmodule

// File: rtl/pairhmm_job_scheduler.sv
// Runs one Pair-HMM job at a time through the systolic array: the host loads
// the read buffer while idle, starts a job, the array gets a one-cycle reset
// pulse and its read requests are served from the buffer, and the final value
// plus the run length come back through a valid/ready result handshake.
// Ports: clock, reset (synchronous, active-high) and bus, which carries the
// load, start, array and result signals.
module pairhmm_job_scheduler
  import pairhmm_job_scheduler_pkg::*;
#(
  parameter int          MAX_LEN = MAX_STRING_LENGTH,
  parameter int          NP      = NUM_PROCS,
  parameter int unsigned TIMEOUT = 1 << 20
) (
  input  logic                    clock,
  input  logic                    reset,
  pairhmm_job_scheduler_if.slave  bus
);

  sched_state_t state;
  sched_state_t state_next;
  logic [31:0]  run_count;
  logic         timed_out;

  assign timed_out = watchdog_expired(run_count, TIMEOUT);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A completion in the same cycle as the watchdog takes priority, and both
  // end in DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (bus.start) state_next = S_ARM;
      S_ARM:  state_next = S_RUN;
      S_RUN:  if (bus.sa_complete || timed_out) state_next = S_DONE;
      S_DONE: if (bus.res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The array is also held in reset for as long as our own reset is high.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.ld_ready  = (state == S_IDLE);
    bus.res_valid = (state == S_DONE);
    bus.sa_reset  = reset || (state == S_ARM);
  end

  // res_cycles includes the cycle in which the job ended.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.sa_len      <= '0;
      bus.sa_tp       <= '0;
      run_count       <= '0;
      bus.res_val     <= '0;
      bus.res_cycles  <= '0;
      bus.res_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.sa_len <= bus.start_len;
            bus.sa_tp  <= bus.start_tp;
          end
        end
        S_ARM: run_count <= '0;
        S_RUN: begin
          run_count <= run_count + 32'd1;
          if (bus.sa_complete) begin
            bus.res_val     <= bus.sa_final_val;
            bus.res_cycles  <= run_count + 32'd1;
            bus.res_timeout <= 1'b0;
          end else if (timed_out) begin
            bus.res_val     <= '0;
            bus.res_cycles  <= run_count + 32'd1;
            bus.res_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pairhmm_read_buffer #(
    .MAX_LEN (MAX_LEN),
    .NP      (NP)
  ) u_buffer (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (bus.ld_valid && (state == S_IDLE)),
    .wr_addr     (bus.ld_addr),
    .wr_ref      (bus.ld_ref),
    .wr_exp      (bus.ld_exp),
    .wr_match    (bus.ld_match),
    .wr_neq      (bus.ld_neq),
    .clear       (state == S_ARM),
    .x_en        (bus.sa_rdx_valid && (state == S_RUN)),
    .x_index     (bus.sa_rdx_index),
    .y_en        (bus.sa_rdy_valid && (state == S_RUN)),
    .y_index     (bus.sa_rdy_index),
    .base_reads  (bus.sa_base_reads),
    .prior_reads (bus.sa_prior_reads)
  );

endmodule

// File: tb/tb_pairhmm_job_scheduler.sv
// Testbench for pairhmm_job_scheduler. A job-level model tracks the buffer
// contents, the phase of the current job and the expected read bundles and
// result; a negedge process compares every DUT output against it. Directed
// jobs add literal expectations: reset, basic job, window overrun,
// result backpressure, watchdog timeout, and reset in the middle of a job.
module tb_pairhmm_job_scheduler;
  import pairhmm_job_scheduler_pkg::*;

  localparam int unsigned TIMEOUT_TB = 16;

  logic clock;
  logic reset;
  pairhmm_job_scheduler_if bus();

  pairhmm_job_scheduler #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_on = 1'b0;

  // model state
  typedef enum {P_IDLE, P_ARM, P_RUN, P_DONE} model_phase_t;
  model_phase_t    m_phase = P_IDLE;
  STRING           m_ref   [MAX_STRING_LENGTH];
  STRING           m_exp   [MAX_STRING_LENGTH];
  logic [63:0]     m_match [MAX_STRING_LENGTH];
  logic [63:0]     m_neq   [MAX_STRING_LENGTH];
  READS            m_reads;
  PRIORS           m_priors;
  logic [ADDR_W-1:0] m_len;
  transition_probs m_tp;
  int unsigned     m_run;
  logic [63:0]     m_res_val;
  logic [31:0]     m_res_cycles;
  logic            m_res_timeout;

  STRING       bases [4];
  logic [63:0] q_match;
  logic [63:0] q_neq;

  task automatic check_output(input string name, input logic [599:0] act,
                              input logic [599:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Job-level model advanced on each rising edge from the driven inputs.
  always @(posedge clock) begin
    if (reset) begin
      m_phase = P_IDLE;
      m_reads = '0;
      m_priors = '0;
      m_len = '0;
      m_tp = '0;
      m_res_val = '0;
      m_res_cycles = '0;
      m_res_timeout = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (bus.ld_valid) begin
            m_ref[bus.ld_addr]   = bus.ld_ref;
            m_exp[bus.ld_addr]   = bus.ld_exp;
            m_match[bus.ld_addr] = bus.ld_match;
            m_neq[bus.ld_addr]   = bus.ld_neq;
          end
          if (bus.start) begin
            m_len = bus.start_len;
            m_tp = bus.start_tp;
            m_phase = P_ARM;
          end
        end
        P_ARM: begin
          m_reads = '0;
          m_priors = '0;
          m_run = 0;
          m_phase = P_RUN;
        end
        P_RUN: begin
          m_run++;
          if (bus.sa_rdx_valid) begin
            m_reads.valid = 1'b1;
            m_reads.reference = m_ref[bus.sa_rdx_index];
          end
          if (bus.sa_rdy_valid) begin
            m_priors.valid = 1'b1;
            for (int i = 0; i < NUM_PROCS; i++) begin
              int p;
              p = int'(bus.sa_rdy_index) + i;
              if (p < MAX_STRING_LENGTH) begin
                m_reads.exp[i]    = m_exp[p[ADDR_W-1:0]];
                m_priors.match[i] = m_match[p[ADDR_W-1:0]];
                m_priors.neq[i]   = m_neq[p[ADDR_W-1:0]];
              end else begin
                m_reads.exp[i]    = STRING_DASH;
                m_priors.match[i] = '0;
                m_priors.neq[i]   = '0;
              end
            end
          end
          if (bus.sa_complete) begin
            m_res_val = bus.sa_final_val;
            m_res_cycles = 32'(m_run);
            m_res_timeout = 1'b0;
            m_phase = P_DONE;
          end else if (m_run == TIMEOUT_TB) begin
            m_res_val = '0;
            m_res_cycles = 32'(m_run);
            m_res_timeout = 1'b1;
            m_phase = P_DONE;
          end
        end
        P_DONE: if (bus.res_ready) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Compare every output against the model, away from the rising edge.
  always @(negedge clock) begin
    if (check_on) begin
      check_output("busy", 600'(bus.busy), 600'(m_phase != P_IDLE));
      check_output("ld_ready", 600'(bus.ld_ready), 600'(m_phase == P_IDLE));
      check_output("sa_reset", 600'(bus.sa_reset), 600'(reset || m_phase == P_ARM));
      check_output("res_valid", 600'(bus.res_valid), 600'(m_phase == P_DONE));
      check_output("sa_len", 600'(bus.sa_len), 600'(m_len));
      check_output("sa_tp", 600'(bus.sa_tp), 600'(m_tp));
      check_output("base_reads", 600'(bus.sa_base_reads), 600'(m_reads));
      check_output("prior_reads", 600'(bus.sa_prior_reads), 600'(m_priors));
      if (m_phase == P_DONE) begin
        check_output("res_val", 600'(bus.res_val), 600'(m_res_val));
        check_output("res_cycles", 600'(bus.res_cycles), 600'(m_res_cycles));
        check_output("res_timeout", 600'(bus.res_timeout), 600'(m_res_timeout));
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] len);
    bus.start = 1'b1;
    bus.start_len = len;
    bus.start_tp = {64'h1111, 64'h2222, 64'h3333, 64'(len)};
    tick();
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clock);
    check_output("arm_pulse", 600'(bus.sa_reset), 600'(1'b1));
    tick();
    @(negedge clock);
    check_output("arm_one_cycle", 600'(bus.sa_reset), 600'(1'b0));
  endtask

  task automatic request(input logic xv, input logic [ADDR_W-1:0] xi,
                         input logic yv, input logic [ADDR_W-1:0] yi);
    bus.sa_rdx_valid = xv;
    bus.sa_rdx_index = xi;
    bus.sa_rdy_valid = yv;
    bus.sa_rdy_index = yi;
    tick();
    bus.sa_rdx_valid = 1'b0;
    bus.sa_rdy_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic finish_job(input logic [63:0] fv, input logic [31:0] cyc);
    bus.sa_complete = 1'b1;
    bus.sa_final_val = fv;
    tick();
    bus.sa_complete = 1'b0;
    @(negedge clock);
    check_output("done_valid", 600'(bus.res_valid), 600'(1'b1));
    check_output("done_val", 600'(bus.res_val), 600'(fv));
    check_output("done_cycles", 600'(bus.res_cycles), 600'(cyc));
    check_output("done_no_timeout", 600'(bus.res_timeout), 600'(1'b0));
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clock);
    check_output("back_to_idle", 600'(bus.busy), 600'(1'b0));
    check_output("idle_ld_ready", 600'(bus.ld_ready), 600'(1'b1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic seen;
    bases = '{STRING_A, STRING_C, STRING_G, STRING_T};
    q_match = $realtobits(0.999);
    q_neq = $realtobits(0.001);
    reset = 1'b1;
    bus.ld_valid = 1'b0;  bus.ld_addr = '0;   bus.ld_ref = STRING_A;
    bus.ld_exp = STRING_A; bus.ld_match = '0; bus.ld_neq = '0;
    bus.start = 1'b0;     bus.start_len = '0; bus.start_tp = '0;
    bus.sa_rdx_valid = 1'b0; bus.sa_rdx_index = '0;
    bus.sa_rdy_valid = 1'b0; bus.sa_rdy_index = '0;
    bus.sa_complete = 1'b0;  bus.sa_final_val = '0;
    bus.res_ready = 1'b0;

    // reset held for two cycles
    tick();
    check_on = 1'b1;
    tick();
    @(negedge clock);
    check_output("rst_sa_reset", 600'(bus.sa_reset), 600'(1'b1));
    check_output("rst_busy", 600'(bus.busy), 600'(1'b0));
    check_output("rst_res_valid", 600'(bus.res_valid), 600'(1'b0));
    check_output("rst_ld_ready", 600'(bus.ld_ready), 600'(1'b1));
    reset = 1'b0;

    // fill the buffer: positions 0..3 hold ACGT with q=30 priors
    for (int a = 0; a < MAX_STRING_LENGTH; a++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr = ADDR_W'(a);
      if (a < 4) begin
        bus.ld_ref = bases[a];
        bus.ld_exp = bases[a];
        bus.ld_match = q_match;
        bus.ld_neq = q_neq;
      end else begin
        bus.ld_ref = bases[a % 4];
        bus.ld_exp = bases[(a + 1) % 4];
        bus.ld_match = {32'hA000_0000, 32'(a)};
        bus.ld_neq = {32'hB000_0000, 32'(a)};
      end
      tick();
    end
    bus.ld_valid = 1'b0;

    // basic job with simultaneous x and y requests
    launch(4);
    check_output("job1_len", 600'(bus.sa_len), 600'(4));
    request(1'b1, 4'd2, 1'b1, 4'd0);
    check_output("job1_ref_G", 600'(bus.sa_base_reads.reference), 600'(STRING_G));
    check_output("job1_ref_valid", 600'(bus.sa_base_reads.valid), 600'(1'b1));
    check_output("job1_exp1_C", 600'(bus.sa_base_reads.exp[1]), 600'(STRING_C));
    check_output("job1_match0", 600'(bus.sa_prior_reads.match[0]), 600'(q_match));
    finish_job($realtobits(0.123), 32'd2);
    handshake();

    // window overrun, then result backpressure
    launch(15);
    request(1'b0, 4'd0, 1'b1, 4'd14);
    check_output("ovr_x_not_valid", 600'(bus.sa_base_reads.valid), 600'(1'b0));
    check_output("ovr_exp0", 600'(bus.sa_base_reads.exp[0]), 600'(STRING_T));
    check_output("ovr_match1", 600'(bus.sa_prior_reads.match[1]), 600'({32'hA000_0000, 32'd15}));
    check_output("ovr_exp2_dash", 600'(bus.sa_base_reads.exp[2]), 600'(STRING_DASH));
    check_output("ovr_exp3_dash", 600'(bus.sa_base_reads.exp[3]), 600'(STRING_DASH));
    check_output("ovr_match2_zero", 600'(bus.sa_prior_reads.match[2]), 600'(64'd0));
    check_output("ovr_neq3_zero", 600'(bus.sa_prior_reads.neq[3]), 600'(64'd0));
    finish_job($realtobits(2.5), 32'd2);
    for (int k = 0; k < 10; k++) begin
      bus.start = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_addr = '0;
      bus.ld_ref = STRING_DASH;
      bus.ld_exp = STRING_DASH;
      tick();
      @(negedge clock);
      check_output("bp_valid", 600'(bus.res_valid), 600'(1'b1));
      check_output("bp_ld_ready", 600'(bus.ld_ready), 600'(1'b0));
      check_output("bp_val", 600'(bus.res_val), 600'($realtobits(2.5)));
      check_output("bp_cycles", 600'(bus.res_cycles), 600'(32'd2));
    end
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    handshake();

    // watchdog: complete never arrives
    launch(3);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      @(negedge clock);
      if (bus.res_valid) seen = 1'b1;
    end
    check_output("to_reached", 600'(seen), 600'(1'b1));
    check_output("to_flag", 600'(bus.res_timeout), 600'(1'b1));
    check_output("to_val", 600'(bus.res_val), 600'(64'd0));
    check_output("to_cycles", 600'(bus.res_cycles), 600'(32'd16));
    handshake();

    // reset during the fifth RUN cycle
    launch(4);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_output("midrst_busy", 600'(bus.busy), 600'(1'b0));
    check_output("midrst_res_valid", 600'(bus.res_valid), 600'(1'b0));

    // new job from retained buffer, with a load in the same cycle as start
    bus.ld_valid = 1'b1;
    bus.ld_addr = 4'd3;
    bus.ld_ref = STRING_A;
    bus.ld_exp = STRING_G;
    bus.ld_match = q_match;
    bus.ld_neq = q_neq;
    launch(4);
    request(1'b1, 4'd3, 1'b1, 4'd0);
    check_output("j4_ref_new", 600'(bus.sa_base_reads.reference), 600'(STRING_A));
    check_output("j4_exp3_new", 600'(bus.sa_base_reads.exp[3]), 600'(STRING_G));
    check_output("j4_exp0_kept", 600'(bus.sa_base_reads.exp[0]), 600'(STRING_A));
    check_output("j4_exp1_kept", 600'(bus.sa_base_reads.exp[1]), 600'(STRING_C));
    finish_job($realtobits(0.75), 32'd2);
    handshake();

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
